// File: rtl/fb_pkg.sv
// Shared definitions for the framebuffer write scheduler: geometry,
// command layout, FSM encoding and a small address helper.
package fb_pkg;

    localparam int FB_WIDTH  = 128;
    localparam int FB_HEIGHT = 96;
    localparam int FB_SIZE   = FB_WIDTH * FB_HEIGHT;

    localparam int ADDR_W       = 14;
    localparam int CMD_W        = 7;
    localparam int COLOR_W      = 3;
    localparam int CMD_SWAP_BIT = 6;
    localparam int ENTRY_W      = ADDR_W + CMD_W;

    // Scheduler states; the encoding is visible on the debug port.
    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_FILL      = 2'd1,
        ST_SWAP_WAIT = 2'd2
    } fb_state_t;

    // One FIFO entry: {addr, data}. The data field is split so that the
    // swap flag (bit 6) and the {B,G,R} colour (bits 2:0) are named.
    // Bits 5:3 carry no meaning and are ignored.
    typedef struct packed {
        logic [ADDR_W-1:0]  addr;
        logic               swap;
        logic [2:0]         rsvd;
        logic [COLOR_W-1:0] color;
    } fb_cmd_t;

    // True when a pixel index falls inside a framebuffer of 'size' pixels.
    function automatic logic addr_in_range(input logic [ADDR_W-1:0] addr,
                                           input int size);
        return int'(addr) < size;
    endfunction

endpackage

// File: rtl/fb_write_scheduler_if.sv
// CPU command port of the write scheduler.
//
// Handshake: the master holds CMD_VALID with CMD_ADDR/CMD_DATA stable; the
// command is transferred on a rising clock edge where CMD_VALID && CMD_READY.
// CMD_READY depends only on FIFO occupancy, never on CMD_VALID.
interface fb_write_scheduler_if;
    import fb_pkg::*;

    logic              CMD_VALID;
    logic [ADDR_W-1:0] CMD_ADDR;
    logic [CMD_W-1:0]  CMD_DATA;
    logic              CMD_READY;

    modport master (
        output CMD_VALID,
        output CMD_ADDR,
        output CMD_DATA,
        input  CMD_READY
    );

    modport slave (
        input  CMD_VALID,
        input  CMD_ADDR,
        input  CMD_DATA,
        output CMD_READY
    );

endinterface

// File: rtl/fb_cmd_fifo.sv
// Synchronous FIFO for CPU commands. The head entry is presented
// combinationally on pop_data; a push is refused while full, even when a
// pop happens in the same cycle.
module fb_cmd_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 21
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic [WIDTH-1:0]       push_data,
    input  logic                   pop,
    output logic [WIDTH-1:0]       pop_data,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full     = (count == CW'(DEPTH));
    assign empty    = (count == '0);
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign pop_data = mem[rd_ptr];

    // Storage array; contents need no reset since count gates every read.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/fb_write_scheduler.sv
// Framebuffer write scheduler. Merges CPU pixel writes (via a small FIFO),
// full back-buffer fills and vblank-synchronised buffer swaps into a single
// one-pixel-per-cycle write stream aimed at the back buffer.
module fb_write_scheduler #(
    parameter int FB_WIDTH   = fb_pkg::FB_WIDTH,
    parameter int FB_HEIGHT  = fb_pkg::FB_HEIGHT,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                            CLK,
    input  logic                            RESET,
    fb_write_scheduler_if.slave             cmd,
    input  logic                            FILL_START,
    input  logic [fb_pkg::COLOR_W-1:0]      FILL_COLOR,
    output logic                            FILL_BUSY,
    input  logic                            VBLANK_START,
    output logic                            SWAP_PENDING,
    output logic                            FB_WE,
    output logic [fb_pkg::ADDR_W-1:0]       FB_WADDR,
    output logic [fb_pkg::COLOR_W-1:0]      FB_WDATA,
    output logic                            FB_WSEL,
    output logic                            DISPLAY_SEL,
    output fb_pkg::fb_state_t               dbg_state,
    output logic [$clog2(FIFO_DEPTH):0]     dbg_fifo_count
);
    import fb_pkg::*;

    localparam int                PIX_COUNT = FB_WIDTH * FB_HEIGHT;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(PIX_COUNT - 1);

    fb_state_t          state;
    logic               fill_pending;
    logic [COLOR_W-1:0] fill_color;
    logic [ADDR_W-1:0]  fill_addr;

    fb_cmd_t            push_entry;
    fb_cmd_t            pop_entry;
    logic               fifo_pop;
    logic               fifo_full;
    logic               fifo_empty;
    logic               rsvd_unused;

    assign push_entry = {cmd.CMD_ADDR, cmd.CMD_DATA};

    fb_cmd_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (ENTRY_W)
    ) u_cmd_fifo (
        .clk       (CLK),
        .rst       (RESET),
        .push      (cmd.CMD_VALID),
        .push_data (push_entry),
        .pop       (fifo_pop),
        .pop_data  (pop_entry),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (dbg_fifo_count)
    );

    // Commands are consumed only while idle; fills and pending swaps hold
    // the queue so that command order relative to them is preserved.
    assign fifo_pop      = (state == ST_IDLE) && !fifo_empty;
    assign cmd.CMD_READY = !fifo_full;

    assign FILL_BUSY    = fill_pending || (state == ST_FILL);
    assign SWAP_PENDING = (state == ST_SWAP_WAIT);
    assign FB_WSEL      = ~DISPLAY_SEL;
    assign dbg_state    = state;
    assign rsvd_unused  = ^pop_entry.rsvd;

    // Scheduler FSM with registered write port and display select.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state        <= ST_IDLE;
            fill_pending <= 1'b0;
            fill_color   <= '0;
            fill_addr    <= '0;
            FB_WE        <= 1'b0;
            FB_WADDR     <= '0;
            FB_WDATA     <= '0;
            DISPLAY_SEL  <= 1'b0;
        end else begin
            FB_WE <= 1'b0;

            // A fill request is remembered once; repeats are dropped until
            // the requested fill has finished.
            if (FILL_START && !fill_pending && (state != ST_FILL)) begin
                fill_pending <= 1'b1;
                fill_color   <= FILL_COLOR;
            end

            case (state)
                ST_IDLE: begin
                    if (!fifo_empty) begin
                        if (pop_entry.swap) begin
                            state <= ST_SWAP_WAIT;
                        end else if (addr_in_range(pop_entry.addr, PIX_COUNT)) begin
                            FB_WE    <= 1'b1;
                            FB_WADDR <= pop_entry.addr;
                            FB_WDATA <= pop_entry.color;
                        end
                    end else if (fill_pending) begin
                        state        <= ST_FILL;
                        fill_pending <= 1'b0;
                        fill_addr    <= '0;
                    end
                end

                ST_FILL: begin
                    FB_WE    <= 1'b1;
                    FB_WADDR <= fill_addr;
                    FB_WDATA <= fill_color;
                    if (fill_addr == LAST_ADDR) begin
                        state <= ST_IDLE;
                    end else begin
                        fill_addr <= fill_addr + ADDR_W'(1);
                    end
                end

                ST_SWAP_WAIT: begin
                    if (VBLANK_START) begin
                        DISPLAY_SEL <= ~DISPLAY_SEL;
                        state       <= ST_IDLE;
                    end
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
